store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-write FIFO between the pipelined core's MEM-stage data port and data memory.
//  Stores retire into the buffer with zero core stall; the buffer drains them to memory over a req/ack port.
//  Loads are forwarded from the buffer on an address hit, otherwise issued to memory.
//  cpu_stall must freeze the whole core pipeline: PC, all pipeline registers and MEM-stage outputs.
// PARAMETERS
//  DEPTH  4   entries; power of two, >=2
//  AW     32  address width
//  DW     32  data width (word stores/loads only)
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       asynchronous, active-high
//  cpu_memwrite in   1       MEM-stage store strobe
//  cpu_memread  in   1       MEM-stage load strobe
//  cpu_addr     in   AW      byte address; [1:0] ignored
//  cpu_wdata    in   DW      store data
//  cpu_rdata    out  DW      load data to core
//  cpu_stall    out  1       freeze core (combinational)
//  mem_req      out  1       memory transaction valid (registered)
//  mem_we       out  1       1=write, 0=read (registered)
//  mem_addr     out  AW      registered, stable while mem_req=1
//  mem_wdata    out  DW      registered, stable while mem_req=1
//  mem_ack      in   1       transaction complete, sampled on clk rising edge
//  mem_rdata    in   DW      read data, valid when mem_ack=1 and mem_we=0
//  count        out  $clog2(DEPTH+1)  occupancy
// BEHAVIOUR
//  Reset (async): count=0, pointers=0, FSM=IDLE.
//   Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_stall=0, cpu_rdata=0.
//   Reset mid-transaction aborts it and discards all buffered stores.
//  Storage: circular FIFO of {addr[AW-1:2], data}; rd/wr pointers wrap mod DEPTH.
//   count=DEPTH is full; count=0 is empty.
//  Store, not full: enqueue at the clock edge; cpu_stall=0.
//  Store, full: cpu_stall=1. An ack that pops the head frees a slot; the store is accepted on the following edge.
//   Net effect: a store arriving while full is accepted one cycle after the ack.
//  Load hit (word address matches any entry): cpu_rdata = data of the youngest matching entry, same cycle; cpu_stall=0.
//  Load miss: cpu_stall=1. The load waits for any in-flight WRITE to complete, then issues a READ.
//   On the READ ack cycle: cpu_rdata=mem_rdata and cpu_stall=0.
//   A pending load has priority over draining further buffered stores.
//  cpu_rdata=0 whenever it is not driving load data.
//  cpu_memwrite and cpu_memread both high: illegal. The store takes precedence; the load is ignored; sim $error.
//  FSM states: IDLE, WRITE, READ.
//   IDLE: a load miss pending -> READ (mem_req=1, mem_we=0, mem_addr=cpu_addr).
//         else count>0 -> WRITE (mem_req=1, mem_we=1, addr/data from head).
//         else stay.
//   WRITE: hold outputs until mem_ack; on ack pop head, mem_req=0, -> IDLE.
//   READ: hold until mem_ack; on ack mem_req=0, -> IDLE.
//   One idle cycle always separates memory transactions; worst-case load-miss latency = write + 1 + read.
//  Enqueue and pop in the same cycle: count unchanged, both pointers advance.
//  The head entry stays in the FIFO until its ack, so loads forward from it during WRITE.
// CONFIGURATION
//  STORE_MERGE_EN defined: a store whose word address equals the youngest entry overwrites that entry's data in place.
//   No enqueue; count unchanged; allowed even when full, so no stall.
//   Exception: that entry is the head in WRITE; then the store enqueues normally.
//  STORE_MERGE_EN undefined: every store enqueues a new entry.
// TESTING
//  1 Assert reset mid-sim -> same cycle: mem_req=0, cpu_stall=0, count=0, cpu_rdata=0.
//  2 Store 0x10=0xDEADBEEF, mem_ack=0 -> count=1.
//    Next edge: mem_req=1, mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF.
//    Pulse mem_ack -> count=0, mem_req=0.
//  3 DEPTH=4, mem_ack=0, stores to 0x0,0x4,0x8,0xC -> count=4.
//    5th store to 0x14: cpu_stall=1 until one cycle after the first ack, then accepted; count=4.
//  4 Store 0x20=1, store 0x20=2, load 0x20 -> cpu_rdata=2 in the load cycle, cpu_stall=0.
//    count=2 without STORE_MERGE_EN; count=1 with it (no drain ack during the sequence).
//  5 One store (0x30) in WRITE, load 0x40 -> stall through write ack, one idle cycle, READ mem_addr=0x40.
//    ack with mem_rdata=0x1234 -> cpu_rdata=0x1234, cpu_stall=0 that cycle.
//  6 Assert reset during READ -> mem_req drops immediately, FSM=IDLE, buffer empty; no spurious pop after release.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the core's MEM-stage data port and data memory.
//   Stores retire into the FIFO without stalling unless it is full. The FIFO drains to
//   memory over a req/ack port. A load that hits the FIFO is forwarded from the youngest
//   matching entry in the same cycle. A load that misses stalls the core and is issued
//   to memory as a READ after any in-flight WRITE completes.
// Optional feature: define STORE_MERGE_EN so that a store to the word held in the youngest
//   entry overwrites that entry in place instead of enqueueing a new one.
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   cpu_memwrite/cpu_memread    MEM-stage store/load strobes
//   cpu_addr, cpu_wdata         byte address (bits [1:0] ignored), store data
//   cpu_rdata, cpu_stall        load data, core freeze (both combinational)
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request, held until mem_ack
//   mem_ack, mem_rdata          memory completion and read data
//   count                       FIFO occupancy
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cpu_memwrite,
   input  logic                       cpu_memread,
   input  logic [AW-1:0]              cpu_addr,
   input  logic [DW-1:0]              cpu_wdata,
   output logic [DW-1:0]              cpu_rdata,
   output logic                       cpu_stall,
   output logic                       mem_req,
   output logic                       mem_we,
   output logic [AW-1:0]              mem_addr,
   output logic [DW-1:0]              mem_wdata,
   input  logic                       mem_ack,
   input  logic [DW-1:0]              mem_rdata,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int TW = AW-2;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
   } entry_t;

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

   entry_t        buf_q [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr, yng_ptr;
   state_t        state;

   logic             st_act, ld_act, full, merge, push, pop, rd_done;
   logic             store_stall, hit, ld_miss;
   logic [DW-1:0]    hit_data;
   logic [DEPTH-1:0] match;
   logic [TW-1:0]    cpu_tag;
   logic             unused_addr_lsb;

   assign cpu_tag         = cpu_addr[AW-1:2];
   assign unused_addr_lsb = ^cpu_addr[1:0];
   assign yng_ptr         = wr_ptr - PW'(1);

   // A simultaneous store and load is illegal; the store wins and the load is dropped.
   assign st_act = cpu_memwrite;
   assign ld_act = cpu_memread & ~cpu_memwrite;
   assign full   = (count == CW'(DEPTH));

   // Slot g is live when its distance from the head is below the occupancy.
   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      logic [PW-1:0] ofs;
      assign ofs      = PW'(g) - rd_ptr;
      assign match[g] = (CW'(ofs) < count) && (buf_q[g].tag == cpu_tag);
   end

   // Walk from head to tail so the youngest matching entry wins.
   always_comb begin
      logic [PW-1:0] idx;
      idx      = '0;
      hit      = 1'b0;
      hit_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if (match[idx]) begin
            hit      = 1'b1;
            hit_data = buf_q[idx].data;
         end
      end
   end

`ifdef STORE_MERGE_EN
   // The head being written to memory is frozen; merging into it would be lost on pop.
   assign merge = st_act && (count != '0) && (buf_q[yng_ptr].tag == cpu_tag) &&
                  !(state == WRITE && yng_ptr == rd_ptr);
`else
   assign merge = 1'b0;
`endif

   // Fullness is taken from the registered count, so a store waiting on a full FIFO is
   // accepted on the edge after the ack that frees a slot.
   assign store_stall = st_act && full && !merge;
   assign push        = st_act && !full && !merge;
   assign pop         = (state == WRITE) && mem_ack;
   assign rd_done     = (state == READ) && mem_ack;
   assign ld_miss     = ld_act && !hit;

   assign cpu_stall = !reset && (store_stall || (ld_miss && !rd_done));

   always_comb begin
      cpu_rdata = '0;
      if (!reset && ld_act) begin
         if (hit)          cpu_rdata = hit_data;
         else if (rd_done) cpu_rdata = mem_rdata;
      end
   end

   // Entry storage carries no reset; liveness is defined by the pointers and count.
   always_ff @(posedge clk) begin
      if (push)       buf_q[wr_ptr]       <= '{tag: cpu_tag, data: cpu_wdata};
      else if (merge) buf_q[yng_ptr].data <= cpu_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Every transaction returns to IDLE on ack, which leaves one idle cycle between them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ld_miss) begin
                  state    <= READ;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= {cpu_tag, 2'b00};
               end else if (count != '0) begin
                  state    <= WRITE;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b1;
                  mem_addr <= {buf_q[rd_ptr].tag, 2'b00};
                  // A merge into the head on this same edge must reach memory too.
                  mem_wdata <= (merge && yng_ptr == rd_ptr) ? cpu_wdata : buf_q[rd_ptr].data;
               end
            end
            WRITE, READ: begin
               if (mem_ack) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)
         assert (!(cpu_memwrite && cpu_memread))
         else $error("store_buffer: load and store asserted together");
   end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios plus randomized traffic against a queue-based
//   reference model of the store buffer and its memory port.
module tb_store_buffer;
   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;
`ifdef STORE_MERGE_EN
   localparam int T4_CNT = 1;
`else
   localparam int T4_CNT = 2;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cpu_memwrite = 1'b0, cpu_memread = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0, cpu_rdata;
   logic          cpu_stall;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic [2:0]    count;

   store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [29:0] tag;
      logic [31:0] data;
   } ent_t;

   // Reference model: buffered stores in order, plus the one transaction on the memory port.
   ent_t        q[$];
   logic        busy = 1'b0, busy_we = 1'b0;
   logic [31:0] busy_addr = '0, busy_data = '0;
   logic        last_stall = 1'b0, obs_stall = 1'b0;
   logic [31:0] obs_rd = '0;

   int n_chk = 0, n_err = 0;

   logic        w = 1'b0, r = 1'b0, ak = 1'b0;
   logic [31:0] a = '0, d = '0, rd = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One core cycle: drive inputs, check at the falling edge, advance the model at the rising edge.
   task automatic step(input logic sw, input logic sr, input logic [31:0] sa,
                       input logic [31:0] sd, input logic sak, input logic [31:0] srd);
      logic        st, ld, hit, merge, exp_stall, start_ok;
      logic [31:0] hd, exp_rd;
      int          sz0;
      cpu_memwrite = sw; cpu_memread = sr; cpu_addr = sa; cpu_wdata = sd;
      mem_ack = sak; mem_rdata = srd;
      @(negedge clk);
      st = sw;
      ld = sr && !sw;
      hit = 1'b0;
      hd = '0;
      foreach (q[i]) if (q[i].tag == sa[31:2]) begin hit = 1'b1; hd = q[i].data; end
      merge = 1'b0;
`ifdef STORE_MERGE_EN
      if (st && q.size() > 0 && q[q.size()-1].tag == sa[31:2] &&
          !(busy && busy_we && q.size() == 1)) merge = 1'b1;
`endif
      exp_stall = (st && !merge && q.size() == DEPTH) ||
                  (ld && !hit && !(busy && !busy_we && sak));
      exp_rd = (ld && hit) ? hd : (ld && busy && !busy_we && sak) ? srd : 32'h0;
      chk("stall", cpu_stall, exp_stall);
      chk("rdata", cpu_rdata, exp_rd);
      chk("count", count, q.size());
      chk("req", mem_req, busy);
      if (busy) begin
         chk("we", mem_we, busy_we);
         chk("maddr", mem_addr, busy_addr);
         if (busy_we) chk("wdata", mem_wdata, busy_data);
      end
      obs_stall  = cpu_stall;
      obs_rd     = cpu_rdata;
      last_stall = exp_stall;
      @(posedge clk);
      sz0 = q.size();
      start_ok = !busy;
      if (busy && sak) begin
         if (busy_we) void'(q.pop_front());
         busy = 1'b0;
      end
      if (st && !exp_stall) begin
         if (merge) q[q.size()-1].data = sd;
         else       q.push_back('{tag: sa[31:2], data: sd});
      end
      if (start_ok) begin
         if (ld && !hit) begin
            busy = 1'b1; busy_we = 1'b0; busy_addr = {sa[31:2], 2'b00};
         end else if (sz0 > 0) begin
            busy = 1'b1; busy_we = 1'b1;
            busy_addr = {q[0].tag, 2'b00}; busy_data = q[0].data;
         end
      end
      #1;
   endtask

   // Reset asserted asynchronously, checked before any clock edge, released after one edge.
   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      chk({tag, "_req"},   mem_req,   0);
      chk({tag, "_stall"}, cpu_stall, 0);
      chk({tag, "_count"}, count,     0);
      chk({tag, "_rdata"}, cpu_rdata, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      q.delete();
      busy = 1'b0;
      last_stall = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && (q.size() > 0 || busy); k++) step(0, 0, 0, 0, busy, 0);
      chk("drained", count, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("por_req", mem_req, 0);
      chk("por_count", count, 0);
      reset = 1'b0;

      // Store drains to memory, ack pops it.
      step(1, 0, 32'h10, 32'hDEADBEEF, 0, 0);
      chk("t2_count", count, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("t2_req", mem_req, 1);
      chk("t2_we", mem_we, 1);
      chk("t2_addr", mem_addr, 32'h10);
      chk("t2_wdata", mem_wdata, 32'hDEADBEEF);
      step(0, 0, 0, 0, 1, 0);
      chk("t2_count0", count, 0);
      chk("t2_req0", mem_req, 0);

      // Fill, then a fifth store waits for the first ack plus one cycle.
      for (int i = 0; i < 4; i++) step(1, 0, 32'(i * 4), 32'(100 + i), 0, 0);
      chk("t3_full", count, 4);
      for (int i = 0; i < 3; i++) step(1, 0, 32'h14, 32'h55, 0, 0);
      chk("t3_stall", obs_stall, 1);
      step(1, 0, 32'h14, 32'h55, 1, 0);
      chk("t3_ackstall", obs_stall, 1);
      step(1, 0, 32'h14, 32'h55, 0, 0);
      chk("t3_accept", obs_stall, 0);
      chk("t3_count", count, 4);
      drain();

      // Two stores to one word, then a forwarded load.
      do_reset("t4rst");
      step(1, 0, 32'h20, 32'h1, 0, 0);
      step(1, 0, 32'h20, 32'h2, 0, 0);
      step(0, 1, 32'h20, 0, 0, 0);
      chk("t4_rdata", obs_rd, 2);
      chk("t4_stall", obs_stall, 0);
      chk("t4_count", count, T4_CNT);
      drain();

      // Load miss behind an in-flight write.
      do_reset("t5rst");
      step(1, 0, 32'h30, 32'h77, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 32'h40, 0, 0, 0);
      step(0, 1, 32'h40, 0, 1, 0);
      chk("t5_wstall", obs_stall, 1);
      step(0, 1, 32'h40, 0, 0, 0);
      chk("t5_rreq", mem_req, 1);
      chk("t5_rwe", mem_we, 0);
      chk("t5_raddr", mem_addr, 32'h40);
      step(0, 1, 32'h40, 0, 1, 32'h1234);
      chk("t5_rdata", obs_rd, 32'h1234);
      chk("t5_stall", obs_stall, 0);
      step(0, 0, 0, 0, 0, 0);

      // Reset during a READ discards the buffer; a late ack pops nothing.
      step(1, 0, 32'h60, 32'h9, 0, 0);
      step(0, 1, 32'h50, 0, 0, 0);
      chk("t6_read", mem_req & ~mem_we, 1);
      do_reset("t6rst");
      step(0, 0, 0, 0, 1, 0);
      chk("t6_count", count, 0);
      chk("t6_req", mem_req, 0);

      // Randomized traffic; a stalled core holds its inputs.
      for (int n = 0; n < 3000; n++) begin
         if (!last_stall) begin
            int k;
            k = $urandom_range(0, 9);
            w = (k < 4);
            r = (k >= 4 && k < 7);
            a = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            d = $urandom;
         end
         ak = busy && ($urandom_range(0, 2) == 0);
         rd = $urandom;
         if (n % 1000 == 500) do_reset("rnd_rst");
         step(w, r, a, d, ak, rd);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
